// File: rtl/mult_bcd_converter.sv
// Captures a signed product on the rising edge of mult_ready and converts its
// magnitude to packed BCD by sequential double-dabble, with sign and blank mask.
module mult_bcd_converter #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mult_ready,
  input  logic [IN_W-1:0]       mult,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic               rdy_q;
  logic               sign_q;
  logic [IN_W-1:0]    mag_q;
  logic [IN_W-1:0]    mag_d;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   work_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIGITS-1:0]  blank_d;
  logic               capture;
  logic               nz;

  // Only a low-to-high transition of the ready level starts a conversion.
  assign capture = mult_ready & ~rdy_q;
  assign mag_d   = mult[IN_W-1] ? (~mult + IN_W'(1)) : mult;

  always_comb begin
    work_d = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_d[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // A digit is blank while it and every more significant digit are zero.
  always_comb begin
    blank_d = '0;
    nz      = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz         = nz | (work_q[4*i +: 4] != 4'd0);
      blank_d[i] = ~nz;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      sign      <= 1'b0;
      bcd       <= '0;
      blank     <= '0;
    end else begin
      rdy_q     <= mult_ready;
      bcd_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture) begin
            sign_q  <= mult[IN_W-1];
            mag_q   <= mag_d;
            work_q  <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          work_q <= {work_d[BCD_W-2:0], mag_q[IN_W-1]};
          mag_q  <= {mag_q[IN_W-2:0], 1'b0};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IN_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd       <= work_q;
          sign      <= sign_q & (work_q != '0);
          blank     <= blank_d;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_bcd_converter.sv
// Randomized bench for mult_bcd_converter: decimal reference model, scoreboard
// of expected {sign, blank, bcd}, latency/busy checks and control corner cases.
module tb_mult_bcd_converter;

  logic        clk;
  logic        reset;
  logic        mult_ready;
  logic [15:0] mult;
  logic        busy;
  logic        bcd_valid;
  logic        sign;
  logic [19:0] bcd;
  logic [4:0]  blank;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;
  logic [25:0] exp_q[$];

  mult_bcd_converter #(.IN_W(16), .DIGITS(5), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .mult_ready(mult_ready), .mult(mult),
    .busy(busy), .bcd_valid(bcd_valid), .sign(sign), .bcd(bcd), .blank(blank)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits of |v|; digit i (i>=1) blank iff |v| < 10^i.
  function automatic logic [25:0] model(input logic [15:0] v);
    int s, m, p;
    logic [19:0] b;
    logic [4:0]  bl;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    b = '0;
    bl = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'((m / p) % 10);
      if (i >= 1 && m < p) bl[i] = 1'b1;
      p = p * 10;
    end
    return {(s < 0), bl, b};
  endfunction

  // scoreboard
  always @(posedge clk) begin
    logic [25:0] e;
    #1;
    if (bcd_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bcd", 32'(bcd), 32'(e[19:0]));
        chk("sign", 32'(sign), 32'(e[25]));
        chk("blank", 32'(blank), 32'(e[24:20]));
      end
    end
  end

  // driver: raise ready with a new product; returns just after the capture edge
  task automatic start(input logic [15:0] v);
    @(negedge clk);
    mult = v;
    mult_ready = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1;
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (bcd_valid) begin
        k = c;
        break;
      end
    end
    if (k == 0) chk("timeout", 32'd1, 32'd0);
    else chk("latency", 32'(k), 32'd17);
    chk("busy_cycles", 32'(busy_cnt), 32'd17);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic convert_pulse(input logic [15:0] v);
    start(v);
    fork
      wait_done();
      begin
        @(negedge clk);
        mult_ready = 1'b0;
      end
    join
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(bcd_valid), 32'd0);
    chk({tag, "_sign"}, 32'(sign), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'd0);
    chk({tag, "_blank"}, 32'(blank), 32'd0);
  endtask

  initial begin
    int vc;
    reset = 1'b0;
    mult_ready = 1'b0;
    mult = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    convert_pulse(16'd0);
    convert_pulse(16'd2438);
    convert_pulse(16'hC080);   // -16256
    convert_pulse(16'd16384);

    // level held high for 100 cycles, mult disturbed mid-conversion
    vc = valid_cnt;
    start(16'd9603);
    fork
      wait_done();
      repeat (5) @(negedge clk) mult = 16'($urandom);
    join
    repeat (82) @(posedge clk);
    chk("hold_one_pulse", 32'(valid_cnt - vc), 32'd1);
    @(negedge clk);
    mult_ready = 1'b0;

    // 1-0-1 on ready during CONVERT is ignored
    vc = valid_cnt;
    start(16'd1234);
    fork
      wait_done();
      begin
        repeat (3) @(negedge clk);
        mult_ready = 1'b0;
        @(negedge clk);
        mult_ready = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    chk("toggle_one_pulse", 32'(valid_cnt - vc), 32'd1);
    @(negedge clk);
    mult_ready = 1'b0;

    // reset in the middle of a conversion
    vc = valid_cnt;
    start(16'h8000);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mult_ready = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    check_zero_outputs("abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    chk("abort_no_valid", 32'(valid_cnt - vc), 32'd0);
    convert_pulse(16'h8000);   // -32768 -> 32768

    // random products, including back-to-back edges right after DONE
    for (int n = 0; n < 25; n++) begin
      convert_pulse(16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_bcd_converter.md
Name: mult_bcd_converter

Overview:
- Downstream consumer of the Booth multiplier subsystem.
- Captures the 16-bit signed product when the multiplier raises its ready flag.
- Converts the product to sign + magnitude and then to five packed BCD digits, using sequential double-dabble (shift-add-3).
- Feeds the display/formatting stage. It also outputs a leading-zero blank mask and a one-cycle done pulse.

Parameters:
- IN_W, 16, width of the signed product input.
- DIGITS, 5, number of BCD digits produced (must cover 2^IN_W-1; 5 for 16 bits).
- CNT_W, 5, width of the iteration counter (must hold IN_W).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- mult_ready  input  1  level flag from the multiplier; product valid while high.
- mult  input  IN_W  signed two's-complement product.
- busy  output  1  high while a conversion is in progress.
- bcd_valid  output  1  one-cycle pulse when new digits are presented.
- sign  output  1  1 = captured product was negative.
- bcd  output  4*DIGITS  packed BCD; [3:0] = units, [19:16] = ten-thousands.
- blank  output  DIGITS  1 = digit is a leading zero; bit 0 (units) is always 0.

Behaviour:
- Reset (reset=0 at an edge):
  - all outputs = 0; FSM = IDLE; counter, shift and work registers cleared.
  - the ready-history register (rdy_q) is cleared.
  - Reset overrides everything, including mid-conversion; a partial result is never presented.
- Edge detect:
  - rdy_q <= mult_ready every cycle.
  - A capture event = mult_ready==1 && rdy_q==0, sampled in IDLE.
  - A level held high yields exactly one conversion.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - On a capture event: latch sign_w = mult[IN_W-1].
  - mag = sign_w ? (~mult + 1) : mult, as IN_W-bit unsigned; -32768 yields 32768, no special case.
  - Clear the BCD work register; counter = 0; busy <= 1; go to CONVERT.
- CONVERT, one iteration per cycle:
  - each work digit >= 5 gets +3;
  - then {work, mag} shifts left 1;
  - counter++.
  - After IN_W iterations (counter reaches IN_W-1 on this cycle), go to DONE.
- DONE, single cycle:
  - bcd <= work; sign <= sign_w; blank <= computed mask; bcd_valid <= 1; busy <= 0; go to IDLE.
- Latency: bcd_valid is high in the cycle following the (IN_W+1)-th rising edge after the capture edge, i.e. 17 clocks for IN_W=16.
- Outputs bcd/sign/blank hold their value until the next DONE or reset. bcd_valid is high for exactly one cycle.
- Zero result: sign forced 0, so no negative zero.
- Blank mask: digit i is blanked if it and all digits above it are 0, for i >= 1. Units are never blanked.
- Capture events while busy (CONVERT/DONE) are ignored and not queued. rdy_q still tracks, so a level that is already high on the return to IDLE does not trigger.
- mult is sampled only at the capture edge; later changes do not affect the conversion in progress.
- Back-to-back: a new rising edge of mult_ready arriving in IDLE immediately after DONE starts a new conversion. The earlier outputs stay until the new DONE.

Test Plan:
- After reset, mult=0, raise mult_ready -> 17 clocks later bcd_valid pulses; bcd=0x00000, sign=0, blank=5'b11110.
- mult=2438 (53*46) -> bcd=0x02438, sign=0, blank=5'b10000; busy high for exactly the conversion cycles.
- mult=-16256 (-128*127) -> sign=1, bcd=0x16256, blank=5'b00000. Also mult=16384 (-128*-128) -> bcd=0x16384, sign=0.
- mult=9603 with mult_ready held high for 100 cycles -> exactly one bcd_valid pulse. Changing mult mid-conversion leaves the result at 0x09603.
- Start a conversion of mult=-32768, pull reset low at iteration 8 -> all outputs 0 next cycle and no bcd_valid. After reset is released, a fresh mult_ready edge converts to bcd=0x32768, sign=1.
- Capture event during CONVERT (mult_ready toggled 1-0-1) -> ignored. First result intact; no second bcd_valid until a new rising edge while IDLE.
